mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 173 +++++++++++++++++
 tb/tb_mac_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: sequencer that streams operand pairs into an external free-running
// multiply-accumulate unit and returns the accumulated dot product.
// Flow: IDLE -> CLR (flush the MAC) -> STREAM (accept len pairs) -> DRAIN
// (let the MAC pipeline empty) -> DONE (hold result until it is taken).
// Optional feature: define MAC_SEQ_ABORT_EN to add an abort input that sends
// any active operation back through CLR to IDLE without producing a result.
module mac_seq #(
    parameter int MAC_LAT = 4,
    parameter int CLR_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_a,
    input  logic [4:0] in_b,
    output logic [4:0] mac_a,
    output logic [4:0] mac_b,
    output logic       mac_clr,
    input  logic [4:0] mac_out,
    output logic [4:0] result,
    output logic       res_valid,
    input  logic       res_ready,
`ifdef MAC_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CW = 8;
    // CLR lasts CLR_CYC cycles; DRAIN lasts MAC_LAT+1 cycles so the last
    // product has fully landed in the accumulator before it is sampled.
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] DRN_LAST = CW'(MAC_LAT);

    state_t          r_state;
    state_t          w_next;
    logic [4:0]      r_cnt;
    logic [CW-1:0]   r_clr_cnt;
    logic [CW-1:0]   r_drn_cnt;
    logic [4:0]      r_mac_a;
    logic [4:0]      r_mac_b;
    logic            r_mac_clr;
    logic [4:0]      r_result;
    logic            w_xfer;
    logic            w_abort;
    logic            w_abort_pend;

`ifdef MAC_SEQ_ABORT_EN
    logic            r_abort;

    assign w_abort      = abort && (r_state != S_IDLE);
    assign w_abort_pend = r_abort;

    // Remember that the current CLR pass came from an abort so it exits to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_abort <= 1'b0;
        end else if (w_abort) begin
            r_abort <= 1'b1;
        end else if (w_next == S_IDLE) begin
            r_abort <= 1'b0;
        end
    end
`else
    assign w_abort      = 1'b0;
    assign w_abort_pend = 1'b0;
`endif

    // in_ready is exactly "state is STREAM", so a valid pair there is a transfer.
    assign w_xfer = (r_state == S_STREAM) && in_valid;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLR;
            S_CLR:    if (r_clr_cnt == CLR_LAST) w_next = w_abort_pend ? S_IDLE : S_STREAM;
            S_STREAM: if (w_xfer && (r_cnt == 5'd1)) w_next = S_DRAIN;
            S_DRAIN:  if (r_drn_cnt == DRN_LAST) w_next = S_DONE;
            S_DONE:   if (res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_CLR;
    end

    // Outputs decoded directly from the state.
    always_comb begin
        in_ready  = (r_state == S_STREAM);
        res_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    // Remaining-pair counter: loaded on start (0 means 16), decremented per transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 5'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cnt <= (len == 4'd0) ? 5'd16 : {1'b0, len};
        end else if (w_xfer) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Dwell counters for CLR and DRAIN; held at zero outside their state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= '0;
            r_drn_cnt <= '0;
        end else begin
            r_clr_cnt <= ((r_state == S_CLR) && !w_abort) ? r_clr_cnt + 1'b1 : '0;
            r_drn_cnt <= ((r_state == S_DRAIN) && !w_abort) ? r_drn_cnt + 1'b1 : '0;
        end
    end

    // MAC operands: the accepted pair for one cycle, otherwise zeros so the
    // free-running accumulator adds nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mac_a <= 5'd0;
            r_mac_b <= 5'd0;
        end else if (w_xfer) begin
            r_mac_a <= in_a;
            r_mac_b <= in_b;
        end else begin
            r_mac_a <= 5'd0;
            r_mac_b <= 5'd0;
        end
    end

    // MAC clear: high while reset is held and for every CLR cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mac_clr <= 1'b1;
        end else begin
            r_mac_clr <= (w_next == S_CLR);
        end
    end

    // Capture the accumulator on the last DRAIN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= 5'd0;
        end else if ((r_state == S_DRAIN) && (r_drn_cnt == DRN_LAST) && !w_abort) begin
            r_result <= mac_out;
        end
    end

    assign mac_a   = r_mac_a;
    assign mac_b   = r_mac_b;
    assign mac_clr = r_mac_clr;
    assign result  = r_result;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: behavioural MAC stub plus a dot-product reference model.
`timescale 1ns/1ps
module tb_mac_seq;
    localparam int MAC_LAT = 4;
    localparam int CLR_CYC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_a = 5'd0;
    logic [4:0] in_b = 5'd0;
    logic [4:0] mac_a;
    logic [4:0] mac_b;
    logic       mac_clr;
    logic [4:0] mac_out;
    logic [4:0] result;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       busy;
`ifdef MAC_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq #(.MAC_LAT(MAC_LAT), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_out(mac_out),
        .result(result), .res_valid(res_valid), .res_ready(res_ready),
`ifdef MAC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy)
    );

    // Behavioural MAC stub: product reaches the accumulator MAC_LAT edges after
    // the operands appear; synchronous clear empties everything.
    logic [4:0] st_pipe [MAC_LAT-1];
    logic [4:0] st_acc;
    assign mac_out = st_acc;
    always @(posedge clk) begin
        if (mac_clr) begin
            st_acc <= 5'd0;
            for (int i = 0; i < MAC_LAT - 1; i++) st_pipe[i] <= 5'd0;
        end else begin
            st_pipe[0] <= 5'(mac_a * mac_b);
            for (int i = 1; i < MAC_LAT - 1; i++) st_pipe[i] <= st_pipe[i-1];
            st_acc <= st_acc + st_pipe[MAC_LAT-2];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [4:0] va [32];
    logic [4:0] vb [32];
    bit         vpat [4];
    int         vpat_n;

    // Observations collected by do_run.
    logic [4:0] o_res;
    int o_pulses, o_clr, o_acc, o_zviol, o_unstable, o_drop, o_busybad, o_post, o_late;
    bit o_timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: dot product of the first L pairs, modulo 32.
    function automatic logic [4:0] ref_dot(input int l);
        int sum = 0;
        for (int i = 0; i < l; i++) sum += int'(va[i]) * int'(vb[i]);
        return 5'(sum % 32);
    endfunction

    // Drive one complete operation and record what the DUT did.
    task automatic do_run(input logic [3:0] lenc, input int n_send, input int gap_pct,
                          input int rdy_hold, input bit start_in_done, input bit start_at_hs);
        int idx = 0;
        int hold = 0;
        int cyc = 0;
        int sc = 0;
        int lval;
        bit pxfer = 0;
        bit hs = 0;
        bit seen = 0;
        bit prv = 0;
        logic [4:0] pa = 5'd0;
        logic [4:0] pb = 5'd0;
        lval = (lenc == 4'd0) ? 16 : int'(lenc);
        o_res = 5'd0; o_pulses = 0; o_clr = 0; o_acc = 0; o_zviol = 0; o_unstable = 0;
        o_drop = 0; o_busybad = 0; o_post = 0; o_late = 0; o_timeout = 0;
        start = 1'b1; len = lenc; in_valid = 1'b0; res_ready = 1'b0;
        tick();
        start = 1'b0;
        while (!hs && cyc < 3000) begin
            cyc++;
            if (mac_a !== (pxfer ? pa : 5'd0) || mac_b !== (pxfer ? pb : 5'd0)) o_zviol++;
            if (mac_clr) o_clr++;
            if (!busy) o_busybad++;
            if (o_acc >= lval && in_ready) o_late++;
            if (res_valid && !prv) o_pulses++;
            if (!res_valid && prv) o_drop++;
            if (res_valid && !seen) begin seen = 1; o_res = result; end
            if (res_valid && result !== o_res) o_unstable++;
            prv = res_valid;
            if (gap_pct < 0) in_valid = (idx < n_send) && in_ready && vpat[sc % vpat_n];
            else in_valid = (idx < n_send) && ($urandom_range(99) >= 32'(gap_pct));
            in_a = in_valid ? va[idx] : 5'($urandom);
            in_b = in_valid ? vb[idx] : 5'($urandom);
            start = 1'b0; res_ready = 1'b0;
            if (res_valid) begin
                if (hold < rdy_hold) begin
                    if (start_in_done && hold == 1) begin start = 1'b1; len = 4'd3; end
                    hold++;
                end else begin
                    res_ready = 1'b1; hs = 1;
                    if (start_at_hs) begin start = 1'b1; len = 4'd2; end
                end
            end
            if (in_ready) sc++;
            pxfer = in_valid && in_ready;
            if (pxfer) begin pa = in_a; pb = in_b; idx++; o_acc++; end
            tick();
        end
        if (!hs) o_timeout = 1;
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (res_valid !== 1'b0 || busy !== 1'b0 || mac_a !== 5'd0 || mac_clr !== 1'b0) o_post++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (mac_a !== 5'd0 || mac_b !== 5'd0) begin errors++; $display("FAIL rst_mac_ab got %0d/%0d exp 0/0", mac_a, mac_b); end
        checks++; if (mac_clr !== 1'b1) begin errors++; $display("FAIL rst_mac_clr got %b exp 1", mac_clr); end
        checks++; if (result !== 5'd0) begin errors++; $display("FAIL rst_result got %0d exp 0", result); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        reset = 1'b1;
        tick();
        checks++; if (mac_clr !== 1'b0) begin errors++; $display("FAIL rst_release_clr got %b exp 0", mac_clr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        va[0] = 5'd1; vb[0] = 5'd2; va[1] = 5'd3; vb[1] = 5'd1; va[2] = 5'd2; vb[2] = 5'd2;
        do_run(4'd3, 3, 0, 0, 1'b0, 1'b0);
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b exp 0", o_timeout); end
        checks++; if (o_res !== 5'd9) begin errors++; $display("FAIL basic_result got %0d exp 9", o_res); end
        checks++; if (o_pulses != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", o_pulses); end
        checks++; if (o_clr != CLR_CYC) begin errors++; $display("FAIL basic_clr_cycles got %0d exp %0d", o_clr, CLR_CYC); end
        checks++; if (o_acc != 3) begin errors++; $display("FAIL basic_accepted got %0d exp 3", o_acc); end
        checks++; if (o_busybad != 0) begin errors++; $display("FAIL basic_busy_low got %0d exp 0", o_busybad); end
        checks++; if (o_zviol != 0) begin errors++; $display("FAIL basic_mac_operands got %0d bad cycles exp 0", o_zviol); end
        checks++; if (o_post != 0) begin errors++; $display("FAIL basic_after_handshake got %0d bad cycles exp 0", o_post); end
    endtask

    task automatic test_gaps();
        logic [4:0] exp;
        va[0] = 5'd3; vb[0] = 5'd7; va[1] = 5'd5; vb[1] = 5'd2;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat_n = 4;
        exp = ref_dot(2);
        do_run(4'd2, 2, -1, 0, 1'b0, 1'b0);
        checks++; if (o_res !== exp) begin errors++; $display("FAIL gaps_result got %0d exp %0d", o_res, exp); end
        checks++; if (o_zviol != 0) begin errors++; $display("FAIL gaps_zero_operands got %0d bad cycles exp 0", o_zviol); end
        checks++; if (o_late != 0) begin errors++; $display("FAIL gaps_ready_after_last got %0d exp 0", o_late); end
        checks++; if (o_acc != 2) begin errors++; $display("FAIL gaps_accepted got %0d exp 2", o_acc); end
    endtask

    task automatic test_len16();
        for (int i = 0; i < 17; i++) begin va[i] = 5'd1; vb[i] = 5'd1; end
        do_run(4'd0, 17, 0, 0, 1'b0, 1'b0);
        checks++; if (o_res !== 5'd16) begin errors++; $display("FAIL len16_result got %0d exp 16", o_res); end
        checks++; if (o_acc != 16) begin errors++; $display("FAIL len16_accepted got %0d exp 16", o_acc); end
        checks++; if (o_late != 0) begin errors++; $display("FAIL len16_extra_ready got %0d exp 0", o_late); end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp;
        for (int i = 0; i < 4; i++) begin va[i] = 5'($urandom_range(1, 31)); vb[i] = 5'($urandom_range(1, 31)); end
        exp = ref_dot(4);
        do_run(4'd4, 4, 20, 5, 1'b1, 1'b1);
        checks++; if (o_res !== exp) begin errors++; $display("FAIL bp_result got %0d exp %0d", o_res, exp); end
        checks++; if (o_unstable != 0) begin errors++; $display("FAIL bp_result_stable got %0d changes exp 0", o_unstable); end
        checks++; if (o_drop != 0 || o_pulses != 1) begin errors++; $display("FAIL bp_valid_held got drops %0d pulses %0d exp 0/1", o_drop, o_pulses); end
        checks++; if (o_post != 0) begin errors++; $display("FAIL bp_start_at_handshake got %0d bad cycles exp 0", o_post); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 4'd5; tick(); start = 1'b0;
        for (int k = 0; k < CLR_CYC + 2; k++) begin
            in_valid = 1'b1; in_a = 5'($urandom_range(1, 31)); in_b = 5'($urandom_range(1, 31));
            tick();
        end
        #2; reset = 1'b0; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b exp 0", in_ready); end
        checks++; if (mac_a !== 5'd0 || mac_b !== 5'd0) begin errors++; $display("FAIL mid_mac_ab got %0d/%0d exp 0/0", mac_a, mac_b); end
        checks++; if (mac_clr !== 1'b1) begin errors++; $display("FAIL mid_mac_clr got %b exp 1", mac_clr); end
        checks++; if (result !== 5'd0) begin errors++; $display("FAIL mid_result got %0d exp 0", result); end
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL mid_busy_valid got %b/%b exp 0/0", busy, res_valid); end
        in_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        tick();
        checks++; if (mac_clr !== 1'b0) begin errors++; $display("FAIL mid_release_clr got %b exp 0", mac_clr); end
        va[0] = 5'd2; vb[0] = 5'd3;
        do_run(4'd1, 1, 0, 0, 1'b0, 1'b0);
        checks++; if (o_res !== 5'd6) begin errors++; $display("FAIL mid_rerun_result got %0d exp 6", o_res); end
        checks++; if (o_pulses != 1) begin errors++; $display("FAIL mid_rerun_pulses got %0d exp 1", o_pulses); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [3:0] lc;
            int l;
            logic [4:0] exp;
            lc = 4'($urandom_range(15));
            l = (lc == 4'd0) ? 16 : int'(lc);
            for (int i = 0; i < 18; i++) begin va[i] = 5'($urandom); vb[i] = 5'($urandom); end
            exp = ref_dot(l);
            do_run(lc, l + int'($urandom_range(2)), 35, int'($urandom_range(3)), 1'b0, 1'b0);
            checks++; if (o_res !== exp) begin errors++; $display("FAIL rand%0d_result got %0d exp %0d", it, o_res, exp); end
            checks++; if (o_acc != l) begin errors++; $display("FAIL rand%0d_accepted got %0d exp %0d", it, o_acc, l); end
            checks++; if (o_zviol != 0 || o_late != 0) begin errors++; $display("FAIL rand%0d_stream got zviol %0d late %0d exp 0/0", it, o_zviol, o_late); end
            checks++; if (o_pulses != 1 || o_clr != CLR_CYC) begin errors++; $display("FAIL rand%0d_ctrl got pulses %0d clr %0d exp 1/%0d", it, o_pulses, o_clr, CLR_CYC); end
        end
    endtask

`ifdef MAC_SEQ_ABORT_EN
    task automatic test_abort();
        logic [4:0] prev;
        int idx = 0;
        int nclr = 0;
        int nrv = 0;
        bit left = 0;
        prev = result;
        start = 1'b1; len = 4'd2; tick(); start = 1'b0;
        for (int k = 0; k < 100 && !left; k++) begin
            in_valid = (idx < 2); in_a = 5'd7; in_b = 5'd3;
            if (in_valid && in_ready) idx++;
            tick();
            if (idx == 2 && !in_ready) left = 1;
        end
        in_valid = 1'b0;
        checks++; if (!left) begin errors++; $display("FAIL abort_reach_drain got %b exp 1", left); end
        abort = 1'b1; tick(); abort = 1'b0;
        for (int k = 0; k < CLR_CYC + 4; k++) begin
            if (mac_clr) nclr++;
            if (res_valid) nrv++;
            tick();
        end
        checks++; if (nclr != CLR_CYC) begin errors++; $display("FAIL abort_clr_cycles got %0d exp %0d", nclr, CLR_CYC); end
        checks++; if (nrv != 0) begin errors++; $display("FAIL abort_res_valid got %0d cycles exp 0", nrv); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %b exp 0", busy); end
        checks++; if (result !== prev) begin errors++; $display("FAIL abort_result got %0d exp %0d", result, prev); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len16();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MAC_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
